// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared defaults, key FSM states and key-code type for the lock datapath
//
// Purpose : common definitions used by key_conditioner, key_debounce_cell and
//           the downstream lock FSM (which reuses key_code_t).
// Ports   : none (package).
// Config  : KEY_MULTI_REJECT_EN is consumed by key_conditioner, not here.

package lock_pkg;

  localparam int NKEYS_DEF           = 4;
  localparam int DEBOUNCE_CYCLES_DEF = 500_000;
  localparam int KEY_CODE_W          = (NKEYS_DEF > 1) ? $clog2(NKEYS_DEF) : 1;

  typedef enum logic [1:0] {
    RELEASED        = 2'd0,
    CONFIRM_PRESS   = 2'd1,
    HELD            = 2'd2,
    CONFIRM_RELEASE = 2'd3
  } key_state_t;

  typedef logic [KEY_CODE_W-1:0] key_code_t;

  // Width of a counter that must be able to hold the value n.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// rtl/key_debounce_cell.sv - per-key synchroniser, debounce FSM and saturating counter
//
// Purpose : conditions one active-low raw pushbutton into a debounced level
//           and a next-cycle press indication.
// Ports   :
//   i_clk       system clock
//   i_rst_n     asynchronous active-low reset
//   i_key_n     raw button, active-low, asynchronous to i_clk
//   o_level     debounced level, active-high (1 = held)
//   o_press_nxt combinational: press is being accepted at the coming edge;
//               the parent registers it so the event and the encoder share a stage

module key_debounce_cell
  import lock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_n,
  output logic o_level,
  output logic o_press_nxt
);

  localparam int               CNT_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             r_sync1;
  logic             r_sync2;
  key_state_t       r_state;
  key_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_pressed;
  logic             w_press_nxt;

  // Synchroniser resets to "released" so a key held through reset is
  // seen as a fresh press and debounced from scratch.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_pressed = ~r_sync2;

  // Saturating increment; the counter never wraps even if held at the limit.
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + CNT_ONE;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= RELEASED;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_press_nxt = 1'b0;
    case (r_state)
      RELEASED: begin
        if (w_pressed) begin
          w_state_nxt = CONFIRM_PRESS;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      CONFIRM_PRESS: begin
        if (!w_pressed) begin
          // Bounce: drop all credit and start over.
          w_state_nxt = RELEASED;
          w_cnt_nxt   = '0;
        end else if (w_cnt_inc == CNT_MAX) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
          w_press_nxt = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      HELD: begin
        if (!w_pressed) begin
          w_state_nxt = CONFIRM_RELEASE;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      CONFIRM_RELEASE: begin
        if (w_pressed) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
        end else if (w_cnt_inc == CNT_MAX) begin
          w_state_nxt = RELEASED;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt = RELEASED;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // The key counts as held until its release is fully confirmed.
  assign o_level     = (r_state == HELD) || (r_state == CONFIRM_RELEASE);
  assign o_press_nxt = w_press_nxt;

endmodule

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - debounced pushbutton front end producing one key event per press
//
// Purpose : synchronises and debounces NKEYS active-low buttons, then encodes
//           accepted presses into single-cycle key events for the lock FSM.
// Ports   :
//   clk        system clock
//   reset      asynchronous active-low reset
//   key_raw    raw buttons, active-low (1 = released), asynchronous
//   key_level  debounced state per key, active-high
//   key_press  one-cycle pulse per key on accepted press
//   key_valid  one-cycle pulse: a single key event this cycle
//   key_code   index of the pressed key, valid with key_valid, held otherwise
//   multi_err  one-cycle pulse: two or more keys accepted in the same cycle
// Config  : KEY_MULTI_REJECT_EN - when defined, same-cycle collisions raise
//           multi_err and suppress key_valid; when undefined the lowest-index
//           key wins and multi_err is constant 0.

module key_conditioner
  import lock_pkg::*;
#(
  parameter int NKEYS           = NKEYS_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CODE_W          = (NKEYS > 1) ? $clog2(NKEYS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NKEYS-1:0]  key_raw,
  output logic [NKEYS-1:0]  key_level,
  output logic [NKEYS-1:0]  key_press,
  output logic              key_valid,
  output logic [CODE_W-1:0] key_code,
  output logic              multi_err
);

  logic [NKEYS-1:0]  w_press_nxt;
  logic [NKEYS-1:0]  r_press;
  logic              r_valid;
  logic [CODE_W-1:0] r_code;
  logic              r_multi;
  logic              w_valid_nxt;
  logic [CODE_W-1:0] w_code_nxt;
  logic              w_multi_nxt;
  logic [CODE_W-1:0] w_low_idx;

  genvar g;
  generate
    for (g = 0; g < NKEYS; g++) begin : g_key
      key_debounce_cell #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_cell (
        .i_clk       (clk),
        .i_rst_n     (reset),
        .i_key_n     (key_raw[g]),
        .o_level     (key_level[g]),
        .o_press_nxt (w_press_nxt[g])
      );
    end
  endgenerate

  // Lowest set index of the presses being accepted this edge.
  always_comb begin
    w_low_idx = '0;
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (w_press_nxt[i]) begin
        w_low_idx = CODE_W'(i);
      end
    end
  end

`ifdef KEY_MULTI_REJECT_EN
  localparam int PC_W = $clog2(NKEYS + 1);
  logic [PC_W-1:0] w_pop;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NKEYS; i++) begin
      w_pop = w_pop + PC_W'(w_press_nxt[i]);
    end
  end

  always_comb begin
    w_valid_nxt = 1'b0;
    w_multi_nxt = 1'b0;
    w_code_nxt  = r_code;
    if (w_pop == PC_W'(1)) begin
      w_valid_nxt = 1'b1;
      w_code_nxt  = w_low_idx;
    end else if (w_pop > PC_W'(1)) begin
      // Collision: flag it and leave the previous code in place.
      w_multi_nxt = 1'b1;
    end
  end
`else
  always_comb begin
    w_valid_nxt = 1'b0;
    w_multi_nxt = 1'b0;
    w_code_nxt  = r_code;
    if (|w_press_nxt) begin
      w_valid_nxt = 1'b1;
      w_code_nxt  = w_low_idx;
    end
  end
`endif

  // Press pulses and encoder outputs share one register stage so that
  // key_valid/key_code/multi_err line up with key_press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_press <= '0;
      r_valid <= 1'b0;
      r_code  <= '0;
      r_multi <= 1'b0;
    end else begin
      r_press <= w_press_nxt;
      r_valid <= w_valid_nxt;
      r_code  <= w_code_nxt;
      r_multi <= w_multi_nxt;
    end
  end

  assign key_press = r_press;
  assign key_valid = r_valid;
  assign key_code  = r_code;
  assign multi_err = r_multi;

endmodule

// File: doc/key_conditioner.md
# key_conditioner

Input conditioning stage that sits directly upstream of the digital-lock state machine. It synchronises the raw active-low pushbuttons, debounces each one independently, and turns each clean press into a single-cycle event with an encoded key index. The lock FSM then consumes one well-formed key event per physical press instead of raw, bouncing button levels.

## Interface
Parameters:
- NKEYS, 4, number of pushbuttons (≥2).
- DEBOUNCE_CYCLES, 500_000, consecutive stable clocks required to accept a level change (10 ms at 50 MHz; ≥2).
- CODE_W, $clog2(NKEYS), width of key_code (derived, min 1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- key_raw  in  NKEYS  raw buttons, active-low (1 = released), asynchronous to clk.
- key_level  out  NKEYS  debounced state, active-high (1 = held).
- key_press  out  NKEYS  one-cycle pulse per key on accepted press.
- key_valid  out  1  one-cycle pulse: exactly one key event this cycle.
- key_code  out  CODE_W  index of pressed key (bit 0 → 0), valid with key_valid.
- multi_err  out  1  one-cycle pulse: ≥2 keys accepted in the same cycle.

## Operation
- Per key: 2-flop synchroniser (reset value 1), then 4-state FSM: RELEASED, CONFIRM_PRESS, HELD, CONFIRM_RELEASE.
- RELEASED: sync=0 → CONFIRM_PRESS, counter=1.
- CONFIRM_PRESS: sync=0 → counter++; when counter reaches DEBOUNCE_CYCLES → HELD, key_level=1, key_press=1 for one cycle. sync=1 → RELEASED, counter=0.
- HELD: sync=1 → CONFIRM_RELEASE, counter=1.
- CONFIRM_RELEASE: sync=1 → counter++; at DEBOUNCE_CYCLES → RELEASED, key_level=0 (no pulse). sync=0 → HELD, counter=0.
- Counter width $clog2(DEBOUNCE_CYCLES+1); saturates, never wraps.
- Encoder (registered with key_press): popcount(key_press)=1 → key_valid=1, key_code=index. Popcount 0 → key_valid=0, key_code holds last value.
- Pressing a second key while the first is held is a normal event; only same-cycle acceptance is a collision.
- Reset: all outputs 0, all FSMs RELEASED, counters 0, sync flops 1. A key held through reset deassertion is debounced normally and produces one press event.

## Timing
- Clean press sampled low at edge 0: sync output low after edge 1; key_level and key_press assert after edge 1+DEBOUNCE_CYCLES.
- key_valid, key_code, multi_err assert in the same cycle as key_press (no extra latency).
- Release latency is identical; key_level falls after edge 1+DEBOUNCE_CYCLES.
- Any bounce during confirmation restarts the full count; no partial credit.
- key_press is never asserted on two consecutive cycles for the same key.
- Reset asserted mid-confirmation: aborts immediately and asynchronously; no pulse is emitted.

## Configuration
- KEY_MULTI_REJECT_EN defined: a same-cycle collision gives multi_err=1, key_valid=0, and key_code unchanged.
- Not defined: the lowest-index key wins, key_valid=1, key_code is that index, and multi_err is tied to 0.
- key_press and key_level are unaffected either way.

## Structure
- Shared package lock_pkg holds the NKEYS default, the DEBOUNCE_CYCLES default, the key FSM state enum (RELEASED/CONFIRM_PRESS/HELD/CONFIRM_RELEASE), and the key-code typedef; the lock FSM reuses the code typedef.
- Sub-module key_debounce_cell (synchroniser + FSM + counter, one key) is instantiated NKEYS times in a generate loop. The encoder and collision logic live in key_conditioner.

## Test plan
Benches use DEBOUNCE_CYCLES=4 and 50 MHz.
- Reset then idle, key_raw=4'b1111 → all outputs 0 for 20 cycles.
- key_raw=4'b1110 held → key_press=4'b0001, key_valid=1, key_code=0 after edge 5; single pulse; key_level[0]=1 until release plus 5 edges.
- key_raw[2] toggles every 2 cycles for 12 cycles, then stays low → no event during bouncing; one event with key_code=2 exactly 5 edges after it settles.
- key_raw=4'b1001 applied on one edge:
  - With KEY_MULTI_REJECT_EN: multi_err=1 and key_valid=0.
  - Without it: key_valid=1 and key_code=1.
- key_raw=4'b0111 low, then reset pulsed after 3 cycles → no pulse before reset; after reset release, key_code=3 event once debounced.
- Hold key 1, then press key 0 10 cycles later → two separate events with codes 1 then 0, multi_err=0.
